raymarch_frame_writer: RTL and testbench



---
 rtl/raymarch_pkg.sv | 33 +++
 rtl/rm_pixel_fifo.sv | 68 ++++++
 rtl/raymarch_frame_writer.sv | 154 +++++++++++++++
 tb/tb_raymarch_frame_writer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/raymarch_pkg.sv
// Shared types and helpers for the raymarch frame writer.
// RM_FRAME_WRITER_RGB332_EN selects the 8-bit RGB332 pixel word instead of 24-bit RGB888.
package raymarch_pkg;

    localparam int CORDW     = 10;
    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;

`ifdef RM_FRAME_WRITER_RGB332_EN
    localparam int PIX_W = 8;
`else
    localparam int PIX_W = 24;
`endif

    typedef logic [PIX_W-1:0] pixel_word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } fw_state_t;

    function automatic pixel_word_t pack_rgb(input logic [7:0] r,
                                             input logic [7:0] g,
                                             input logic [7:0] b);
`ifdef RM_FRAME_WRITER_RGB332_EN
        return {r[7:5], g[7:5], b[7:6]};
`else
        return {r, g, b};
`endif
    endfunction

endpackage

// File: rtl/rm_pixel_fifo.sv
// Single-clock FIFO with a registered show-ahead read port: dout_o holds the head
// entry whenever empty_o is low. A push into a full FIFO is accepted when a pop is in the same cycle.
module rm_pixel_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_next;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rd_next = rd_ptr_q + AW'(1);
    assign dout_o  = dout_q;
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
        // The output register always mirrors the entry that will be at the head next cycle.
        dout_d = dout_q;
        if (do_pop && (count_q != (AW+1)'(1))) begin
            dout_d = mem_q[rd_next];
        end else if (do_push && (empty_o || do_pop)) begin
            dout_d = din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_next;
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/raymarch_frame_writer.sv
// Scans a frame of coordinates into the raymarcher, tags returning colours with their
// address through a latency-matched delay line and streams them to the framebuffer.
// Define RM_FRAME_WRITER_RGB332_EN for 8-bit RGB332 pixel words (24-bit RGB888 otherwise).
module raymarch_frame_writer
    import raymarch_pkg::*;
#(
    parameter int H_RES        = H_RES_DEF,
    parameter int V_RES        = V_RES_DEF,
    parameter int PIPE_LATENCY = 32,
    parameter int FIFO_DEPTH   = 64,
    parameter int ADDR_W       = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic [CORDW-1:0]  pixel_x,
    output logic [CORDW-1:0]  pixel_y,
    input  logic [7:0]        red,
    input  logic [7:0]        green,
    input  logic [7:0]        blue,
    output logic              mem_wr_valid,
    input  logic              mem_wr_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output pixel_word_t       mem_data
);

    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int CW  = FAW + 2;
    localparam int FW  = ADDR_W + PIX_W;
    localparam logic [CORDW-1:0] X_LAST = CORDW'(H_RES - 1);
    localparam logic [CORDW-1:0] Y_LAST = CORDW'(V_RES - 1);

    fw_state_t         state_q, state_d;
    logic [CORDW-1:0]  nx_q, nx_d, ny_q, ny_d;
    logic [CORDW-1:0]  px_q, px_d, py_q, py_d;
    logic [ADDR_W-1:0] naddr_q, naddr_d;
    logic              issue;
    logic              drained;

    logic [PIPE_LATENCY:0] dl_vld_q;
    logic [ADDR_W-1:0]     dl_addr_q [PIPE_LATENCY+1];
    logic [CW-1:0]         inflight, credit_sum;

    logic [FAW:0]    fifo_count;
    logic            fifo_full, fifo_empty;
    logic [FW-1:0]   fifo_dout;

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= PIPE_LATENCY; i++) begin
            inflight = inflight + CW'(dl_vld_q[i]);
        end
    end

    // Every coordinate in flight already owns a FIFO slot, so the FIFO can never overflow.
    assign credit_sum = CW'(fifo_count) + inflight;
    assign drained    = (dl_vld_q == '0) && fifo_empty;

    always_comb begin
        state_d    = state_q;
        nx_d       = nx_q;
        ny_d       = ny_q;
        px_d       = px_q;
        py_d       = py_q;
        naddr_d    = naddr_q;
        issue      = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SCAN;
                    nx_d    = '0;
                    ny_d    = '0;
                    naddr_d = '0;
                end
            end
            ST_SCAN: begin
                if (!fifo_full && (credit_sum < CW'(FIFO_DEPTH))) begin
                    issue   = 1'b1;
                    px_d    = nx_q;
                    py_d    = ny_q;
                    naddr_d = naddr_q + ADDR_W'(1);
                    if (nx_q == X_LAST) begin
                        nx_d = '0;
                        ny_d = ny_q + CORDW'(1);
                        if (ny_q == Y_LAST) state_d = ST_DRAIN;
                    end else begin
                        nx_d = nx_q + CORDW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (drained) begin
                    frame_done = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            nx_q     <= '0;
            ny_q     <= '0;
            px_q     <= '0;
            py_q     <= '0;
            naddr_q  <= '0;
            dl_vld_q <= '0;
        end else begin
            state_q  <= state_d;
            nx_q     <= nx_d;
            ny_q     <= ny_d;
            px_q     <= px_d;
            py_q     <= py_d;
            naddr_q  <= naddr_d;
            dl_vld_q <= {dl_vld_q[PIPE_LATENCY-1:0], issue};
        end
    end

    // Address rides alongside the valid bit; bubbles carry don't-care addresses.
    always_ff @(posedge clk) begin
        dl_addr_q[0] <= naddr_q;
        for (int i = 1; i <= PIPE_LATENCY; i++) begin
            dl_addr_q[i] <= dl_addr_q[i-1];
        end
    end

    rm_pixel_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (dl_vld_q[PIPE_LATENCY]),
        .din_i   ({dl_addr_q[PIPE_LATENCY], pack_rgb(red, green, blue)}),
        .pop_i   (mem_wr_ready),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign busy         = (state_q != ST_IDLE);
    assign pixel_x      = px_q;
    assign pixel_y      = py_q;
    assign mem_wr_valid = !fifo_empty;
    assign mem_addr     = fifo_dout[FW-1:PIX_W];
    assign mem_data     = fifo_dout[PIX_W-1:0];

endmodule

// File: tb/tb_raymarch_frame_writer.sv
// Scoreboard bench for raymarch_frame_writer with a behavioural raymarcher stand-in.
module tb_raymarch_frame_writer;

    localparam int H  = 4;
    localparam int V  = 4;
    localparam int L  = 3;
    localparam int D  = 8;
    localparam int AW = 19;
    localparam int PW = $bits(raymarch_pkg::pixel_word_t);

    logic clk = 1'b0;
    logic rst_n, start, mem_wr_ready;
    logic busy, frame_done, mem_wr_valid;
    logic [9:0] pixel_x, pixel_y;
    logic [7:0] red, green, blue;
    logic [AW-1:0] mem_addr;
    raymarch_pkg::pixel_word_t mem_data;

    int checks = 0;
    int fails = 0;
    int done_cnt = 0;
    int wr_total = 0;
    logic rnd_ready = 1'b0;
    logic col_const = 1'b0;
    logic [7:0] salt = 8'h00;
    logic [AW+PW-1:0] exp_q[$];

    always #5 clk = ~clk;

    raymarch_frame_writer #(
        .H_RES(H), .V_RES(V), .PIPE_LATENCY(L), .FIFO_DEPTH(D), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .frame_done(frame_done),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .red(red), .green(green), .blue(blue),
        .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
        .mem_addr(mem_addr), .mem_data(mem_data)
    );

    // Raymarcher stand-in: colour appears L cycles after its coordinate.
    logic [9:0] shx [L];
    logic [9:0] shy [L];
    always @(posedge clk) begin
        shx[0] <= pixel_x;
        shy[0] <= pixel_y;
        for (int i = 1; i < L; i++) begin
            shx[i] <= shx[i-1];
            shy[i] <= shy[i-1];
        end
    end
    assign red   = col_const ? 8'hE0 : 8'(shx[L-1] + (shy[L-1] << 4));
    assign green = col_const ? 8'h1C : (8'(shx[L-1]) ^ salt);
    assign blue  = col_const ? 8'hC3 : (8'(shy[L-1] * 37) + salt);

    function automatic logic [PW-1:0] pack(input logic [23:0] c);
`ifdef RM_FRAME_WRITER_RGB332_EN
        return {c[23:21], c[15:13], c[7:6]};
`else
        return c;
`endif
    endfunction

    function automatic logic [PW-1:0] exp_data(input int a);
        int x, y;
        x = a % H;
        y = a / H;
        if (col_const) return pack(24'hE01CC3);
        return pack({8'(x + 16 * y), 8'(x) ^ salt, 8'(y * 37) + salt});
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every accepted write and checks hold-stability while stalled.
    initial begin
        logic stall_prev;
        logic [AW+PW-1:0] held, e;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (frame_done) done_cnt++;
                if (stall_prev) begin
                    checks++;
                    if (!mem_wr_valid || {mem_addr, mem_data} !== held) begin
                        fails++;
                        $display("FAIL stall_stable: got v=%0b %0h expected v=1 %0h",
                                 mem_wr_valid, {mem_addr, mem_data}, held);
                    end
                end
                stall_prev = 1'b0;
                if (mem_wr_valid && mem_wr_ready) begin
                    wr_total++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_write: got addr %0h expected no write", mem_addr);
                    end else begin
                        e = exp_q.pop_front();
                        if ({mem_addr, mem_data} !== e) begin
                            fails++;
                            $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                                     mem_addr, mem_data, e[AW+PW-1:PW], e[PW-1:0]);
                        end
                    end
                end else if (mem_wr_valid) begin
                    stall_prev = 1'b1;
                    held = {mem_addr, mem_data};
                end
            end
        end
    end

    // Random back-pressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) mem_wr_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic begin_frame();
        for (int a = 0; a < H * V; a++) exp_q.push_back({AW'(a), exp_data(a)});
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input int budget, input int d0, output int n);
        n = 1;
        while (!frame_done && n < budget) begin
            tick();
            n++;
        end
        if (!frame_done) begin
            checks++;
            fails++;
            $display("FAIL %s_timeout: got no frame_done expected within %0d cycles", tag, budget);
        end
        tick();
        check({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
        check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int n, d0, w0, w, k;
        rst_n = 1'b0;
        start = 1'b0;
        mem_wr_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        check("rst_busy", 64'(busy), 0);
        check("rst_frame_done", 64'(frame_done), 0);
        check("rst_wr_valid", 64'(mem_wr_valid), 0);
        check("rst_pixel_x", 64'(pixel_x), 0);
        check("rst_pixel_y", 64'(pixel_y), 0);
        check("rst_mem_addr", 64'(mem_addr), 0);
        check("rst_mem_data", 64'(mem_data), 0);

        // Full-rate frame: latency from start to frame_done.
        salt = 8'h00;
        d0 = done_cnt;
        begin_frame();
        finish_frame("basic", 500, d0, n);
        check("frame_latency", 64'(n), 64'(H * V + L + 3));

        // Back-pressure: issue must stop once FIFO plus in-flight reaches D.
        salt = 8'h5A;
        d0 = done_cnt;
        w0 = wr_total;
        begin_frame();
        k = 0;
        while (wr_total - w0 < 2 && k < 200) begin tick(); k++; end
        mem_wr_ready = 1'b0;
        w = wr_total - w0;
        repeat (20) tick();
        check("stall_busy", 64'(busy), 64'd1);
        check("stall_issued", 64'(int'(pixel_y) * H + int'(pixel_x) + 1), 64'(w + D));
        check("stall_no_write", 64'(wr_total - w0), 64'(w));
        mem_wr_ready = 1'b1;
        finish_frame("stall", 500, d0, n);

        // start while busy is ignored.
        salt = 8'h33;
        d0 = done_cnt;
        w0 = wr_total;
        begin_frame();
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_frame("restart", 500, d0, n);
        repeat (40) tick();
        check("restart_single_done", 64'(done_cnt - d0), 64'd1);
        check("restart_writes", 64'(wr_total - w0), 64'(H * V));
        check("restart_idle", 64'(busy), 64'd0);

        // Reset mid-frame at pixel 3.
        salt = 8'h77;
        d0 = done_cnt;
        w0 = wr_total;
        begin_frame();
        k = 0;
        while (!(busy && pixel_x == 10'd3 && pixel_y == 10'd0) && k < 200) begin tick(); k++; end
        check("reach_pixel3", 64'(pixel_x), 64'd3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        check("mid_rst_busy", 64'(busy), 0);
        check("mid_rst_valid", 64'(mem_wr_valid), 0);
        check("mid_rst_px", 64'(pixel_x), 0);
        check("mid_rst_py", 64'(pixel_y), 0);
        check("mid_rst_addr", 64'(mem_addr), 0);
        check("mid_rst_data", 64'(mem_data), 0);
        check("mid_rst_done", 64'(frame_done), 0);
        w0 = wr_total;
        repeat (30) tick();
        check("post_rst_no_writes", 64'(wr_total - w0), 64'd0);
        check("post_rst_no_done", 64'(done_cnt - d0), 64'd0);
        salt = 8'h91;
        begin_frame();
        finish_frame("after_rst", 500, d0, n);

        // Constant colour exercises the pixel packing.
        col_const = 1'b1;
        d0 = done_cnt;
        begin_frame();
        finish_frame("const_col", 500, d0, n);
        col_const = 1'b0;

        // Random 50% ready over several frames.
        rnd_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            salt = 8'($urandom);
            d0 = done_cnt;
            w0 = wr_total;
            begin_frame();
            finish_frame("random", 2000, d0, n);
            check("random_writes", 64'(wr_total - w0), 64'(H * V));
        end
        rnd_ready = 1'b0;
        mem_wr_ready = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
